// File: rtl/regfile_read_sched.sv
// ---------------------------------------------------------------------------
// regfile_read_sched
//
// Schedules two requesters onto the single shared read port of the register
// file. The read port is a 32-way combinational select: this block drives the
// registered select index (mux_sel) and samples the selected data (mux_data)
// one cycle later.
//
//   requester A : operand fetch
//   requester B : debug / trap unit
//
// Pipeline
//   accept edge : granted index loaded into mux_sel, stage-1 marker set
//   next edge   : port data (or zero / forwarded write-back data) loaded into
//                 the owner's rdata register, owner's rvalid set
//   rvalid is then held, with rdata stable, until the owner takes it.
//
// Handshakes (same rule on both sides of both requesters)
//   A transfer happens on a rising edge where valid and ready are both high.
//   - request side : x_valid/x_addr come from the requester, x_ready from here.
//                    The requester holds x_valid and x_addr until it sees the
//                    transfer. x_ready never depends combinationally on
//                    x_rready.
//   - response side: x_rvalid/x_rdata come from here, x_rready from the
//                    requester. x_rdata is stable while x_rvalid & !x_rready.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   a_valid/a_addr/a_ready  requester A read request
//   a_rvalid/a_rdata/a_rready  requester A read response
//   b_*                     same for requester B
//   mux_sel                 registered select index to the read port
//   mux_data                read-port data for the current mux_sel
//   wr_en/wr_addr/wr_data   register-file write-back this cycle (forwarding)
// ---------------------------------------------------------------------------
module regfile_read_sched #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              a_rready,

  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              b_rready,

  output logic [ADDR_W-1:0] mux_sel,
  input  logic [DATA_W-1:0] mux_data,

  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  // The hard-wired zero register is the all-ones index (31 for 5-bit indices).
  localparam logic [ADDR_W-1:0] ZERO_IDX = '1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic              a_busy_q,     a_busy_d;
  logic              b_busy_q,     b_busy_d;
  owner_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] mux_sel_q,    mux_sel_d;
  logic              s1_valid_q,   s1_valid_d;
  owner_e            s1_owner_q,   s1_owner_d;
  logic              a_rvalid_q,   a_rvalid_d;
  logic              b_rvalid_q,   b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q,    a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q,    b_rdata_d;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic a_elig;
  logic b_elig;
  logic grant_a;
  logic grant_b;

  always_comb begin
    a_elig  = a_valid & ~a_busy_q;
    b_elig  = b_valid & ~b_busy_q;
    // On a tie the requester that did not win last time gets the port.
    grant_a = a_elig & (~b_elig | (last_grant_q == OWN_B));
    grant_b = b_elig & ~grant_a;
  end

  // ready is withheld from the tie loser so a transfer can only ever happen
  // for the granted requester. An idle requester shows ready whenever the
  // other side is not competing, so a fresh valid is accepted the same cycle.
  always_comb begin
    a_ready = reset_n & ~a_busy_q & (grant_a | ~b_elig);
    b_ready = reset_n & ~b_busy_q & (grant_b | ~a_elig);
  end

  // -------------------------------------------------------------------------
  // Stage-2 result: zero register, write-back forwarding, port data.
  // A write in the stage-1 cycle has already reached the register file, so
  // only a write in this (stage-2) cycle needs to be bypassed.
  // -------------------------------------------------------------------------
  logic              s2_zero;
  logic              s2_fwd;
  logic [DATA_W-1:0] s2_result;

  always_comb begin
    s2_zero   = (ZERO_REG != 0) && (mux_sel_q == ZERO_IDX);
    s2_fwd    = wr_en && (wr_addr == mux_sel_q);
    s2_result = mux_data;
    if (s2_zero) begin
      s2_result = '0;
    end else if (s2_fwd) begin
      s2_result = wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state: select register and stage-1 marker
  // -------------------------------------------------------------------------
  always_comb begin
    mux_sel_d    = mux_sel_q;
    s1_valid_d   = grant_a | grant_b;
    s1_owner_d   = s1_owner_q;
    last_grant_d = last_grant_q;
    if (grant_a) begin
      mux_sel_d    = a_addr;
      s1_owner_d   = OWN_A;
      last_grant_d = OWN_A;
    end else if (grant_b) begin
      mux_sel_d    = b_addr;
      s1_owner_d   = OWN_B;
      last_grant_d = OWN_B;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state: requester A
  // busy covers accept through response hand-off, so a response and a new
  // accept for the same requester never land on the same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    a_busy_d   = a_busy_q;
    a_rvalid_d = a_rvalid_q;
    a_rdata_d  = a_rdata_q;
    if (a_rvalid_q && a_rready) begin
      a_busy_d   = 1'b0;
      a_rvalid_d = 1'b0;
    end
    if (s1_valid_q && (s1_owner_q == OWN_A)) begin
      a_rvalid_d = 1'b1;
      a_rdata_d  = s2_result;
    end
    if (grant_a) begin
      a_busy_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state: requester B
  // -------------------------------------------------------------------------
  always_comb begin
    b_busy_d   = b_busy_q;
    b_rvalid_d = b_rvalid_q;
    b_rdata_d  = b_rdata_q;
    if (b_rvalid_q && b_rready) begin
      b_busy_d   = 1'b0;
      b_rvalid_d = 1'b0;
    end
    if (s1_valid_q && (s1_owner_q == OWN_B)) begin
      b_rvalid_d = 1'b1;
      b_rdata_d  = s2_result;
    end
    if (grant_b) begin
      b_busy_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers. Reset drops any read in flight; last_grant starts at B so
  // that A wins the first tie.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_busy_q     <= 1'b0;
      b_busy_q     <= 1'b0;
      last_grant_q <= OWN_B;
      mux_sel_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_owner_q   <= OWN_A;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      a_busy_q     <= a_busy_d;
      b_busy_q     <= b_busy_d;
      last_grant_q <= last_grant_d;
      mux_sel_q    <= mux_sel_d;
      s1_valid_q   <= s1_valid_d;
      s1_owner_q   <= s1_owner_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mux_sel  = mux_sel_q;
  assign a_rvalid = a_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rvalid = b_rvalid_q;
  assign b_rdata  = b_rdata_q;

endmodule
